light_conflict_monitor: RTL and testbench

Independent safety monitor that reads the lamp outputs of the two light state machines at an intersection (approach A and approach B) and checks them against the legal signalling rules. On a conflict, illegal lamp pattern, short or skipped yellow, or a stuck phase, it latches a fault and drives `out_issue`. `out_issue` feeds the `in_issue` input of both light state machines, which forces them into flashing red. The block sits beside the light state machines in the intersection top level. It is the consumer of their lamp interface and the producer of their issue input.

---
 rtl/light_conflict_monitor_pkg.sv | 37 +++
 rtl/approach_checker.sv | 72 +++++++
 rtl/light_conflict_monitor.sv | 113 +++++++++++
 tb/tb_light_conflict_monitor.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_conflict_monitor_pkg.sv
// Shared lamp bit positions, monitor states and fault codes for the intersection conflict monitor.
// Lamp vector order is {pedestrian, left_turn, green, yellow, red}.
package light_conflict_monitor_pkg;

  localparam int RED        = 0;
  localparam int YELLOW     = 1;
  localparam int GREEN      = 2;
  localparam int LEFT_TURN  = 3;
  localparam int PEDESTRIAN = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } mon_state_t;

  // Numeric order doubles as priority: lowest code wins on a tie.
  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_CONFLICT = 3'd1,
    FC_PAT_A    = 3'd2,
    FC_PAT_B    = 3'd3,
    FC_YEL_A    = 3'd4,
    FC_YEL_B    = 3'd5,
    FC_STUCK_A  = 3'd6,
    FC_STUCK_B  = 3'd7
  } fault_code_t;

  function automatic logic lamp_go(input logic [4:0] x);
    return x[GREEN] | x[YELLOW] | x[LEFT_TURN];
  endfunction

  function automatic logic lamp_illegal(input logic [4:0] x);
    return ($countones(x[LEFT_TURN:RED]) != 1) || (x[PEDESTRIAN] && !x[GREEN]);
  endfunction

endpackage

// File: rtl/approach_checker.sv
// Per-approach checks on the registered lamp pattern: illegal-pattern filter, yellow timing, stuck phase.
// Fault outputs are combinational from the current registered pattern and counters; counters run only while active.
module approach_checker
  import light_conflict_monitor_pkg::*;
#(
  parameter logic [31:0] FILTER_TICKS     = 32'd50000,
  parameter logic [31:0] MIN_YELLOW_TICKS = 32'd240000000,
  parameter logic [31:0] STUCK_TICKS      = 32'd3000000000
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_active,
  input  logic [4:0] in_cur,
  input  logic [4:0] in_prev,
  output logic       out_go,
  output logic       out_pattern_fault,
  output logic       out_yellow_fault,
  output logic       out_stuck_fault
);

  logic [31:0] pat_cnt_q, pat_cnt_d;
  logic [31:0] yel_cnt_q, yel_cnt_d;
  logic [31:0] stuck_cnt_q, stuck_cnt_d;
  logic        yellow_start_seen_q, yellow_start_seen_d;
  logic        illegal, unchanged, yellow_rise, yellow_to_red, green_to_red;

  always_comb begin
    illegal       = lamp_illegal(in_cur);
    unchanged     = (in_cur == in_prev);
    yellow_rise   = in_cur[YELLOW] & ~in_prev[YELLOW];
    yellow_to_red = in_prev[YELLOW] & in_cur[RED] & ~in_cur[YELLOW];
    green_to_red  = in_prev[GREEN] & in_cur[RED] & ~in_cur[GREEN];

    pat_cnt_d           = '0;
    yel_cnt_d           = '0;
    stuck_cnt_d         = '0;
    yellow_start_seen_d = 1'b0;
    if (in_active) begin
      if (illegal) pat_cnt_d = pat_cnt_q + 32'd1;
      // yel_cnt holds the number of cycles the current yellow has been shown.
      if (in_cur[YELLOW]) begin
        if (yellow_rise) yel_cnt_d = 32'd1;
        else yel_cnt_d = (yel_cnt_q == MIN_YELLOW_TICKS) ? yel_cnt_q : yel_cnt_q + 32'd1;
      end
      if (unchanged) stuck_cnt_d = (stuck_cnt_q == STUCK_TICKS) ? stuck_cnt_q : stuck_cnt_q + 32'd1;
      yellow_start_seen_d = yellow_rise | (yellow_start_seen_q & in_cur[YELLOW]);
    end
  end

  assign out_go            = lamp_go(in_cur);
  assign out_pattern_fault = in_active & illegal & (pat_cnt_q >= FILTER_TICKS - 32'd1);
  assign out_stuck_fault   = in_active & unchanged & (stuck_cnt_q >= STUCK_TICKS - 32'd1);
  // A yellow already running when monitoring began has no trusted start, so only green->red is checked then.
  assign out_yellow_fault  = in_active &
                             (green_to_red |
                              (yellow_to_red & yellow_start_seen_q & (yel_cnt_q < MIN_YELLOW_TICKS)));

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      pat_cnt_q           <= '0;
      yel_cnt_q           <= '0;
      stuck_cnt_q         <= '0;
      yellow_start_seen_q <= 1'b0;
    end else begin
      pat_cnt_q           <= pat_cnt_d;
      yel_cnt_q           <= yel_cnt_d;
      stuck_cnt_q         <= stuck_cnt_d;
      yellow_start_seen_q <= yellow_start_seen_d;
    end
  end

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety monitor for two approach lamp sets; latches the first fault and raises out_issue to force flashing red.
// Unfiltered faults show two edges after the lamp change; filtered ones after CONFLICT_FILTER_TICKS+1 edges.
module light_conflict_monitor
  import light_conflict_monitor_pkg::*;
#(
  parameter logic [31:0] CONFLICT_FILTER_TICKS = 32'd50000,
  parameter logic [31:0] MIN_YELLOW_TICKS      = 32'd240000000,
  parameter logic [31:0] STUCK_TICKS           = 32'd3000000000
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_enable,
  input  logic [4:0] in_a_lights,
  input  logic [4:0] in_b_lights,
  output logic       out_issue,
  output logic [2:0] out_fault_code,
  output logic       out_monitor_ok
);

  logic [4:0]  a_q, a_p, b_q, b_p;
  mon_state_t  state_q, state_d;
  fault_code_t code_q, code_d, first_fault;
  logic        issue_q, issue_d, monitor_ok_q, monitor_ok_d;
  logic [31:0] conf_cnt_q, conf_cnt_d;
  logic        active, conflict, conflict_fault;
  logic        a_go, a_pat, a_yel, a_stuck;
  logic        b_go, b_pat, b_yel, b_stuck;

  // Dropping enable stops checking in the same cycle so counters clear on the next edge.
  assign active = (state_q == ST_MONITOR) && in_enable;

  approach_checker #(
    .FILTER_TICKS    (CONFLICT_FILTER_TICKS),
    .MIN_YELLOW_TICKS(MIN_YELLOW_TICKS),
    .STUCK_TICKS     (STUCK_TICKS)
  ) u_chk_a (
    .in_clock(in_clock), .in_reset(in_reset), .in_active(active),
    .in_cur(a_q), .in_prev(a_p),
    .out_go(a_go), .out_pattern_fault(a_pat), .out_yellow_fault(a_yel), .out_stuck_fault(a_stuck)
  );

  approach_checker #(
    .FILTER_TICKS    (CONFLICT_FILTER_TICKS),
    .MIN_YELLOW_TICKS(MIN_YELLOW_TICKS),
    .STUCK_TICKS     (STUCK_TICKS)
  ) u_chk_b (
    .in_clock(in_clock), .in_reset(in_reset), .in_active(active),
    .in_cur(b_q), .in_prev(b_p),
    .out_go(b_go), .out_pattern_fault(b_pat), .out_yellow_fault(b_yel), .out_stuck_fault(b_stuck)
  );

  always_comb begin
    conflict       = a_go & b_go;
    conf_cnt_d     = (active && conflict) ? conf_cnt_q + 32'd1 : '0;
    conflict_fault = active && conflict && (conf_cnt_q >= CONFLICT_FILTER_TICKS - 32'd1);

    first_fault = FC_NONE;
    if      (conflict_fault) first_fault = FC_CONFLICT;
    else if (a_pat)          first_fault = FC_PAT_A;
    else if (b_pat)          first_fault = FC_PAT_B;
    else if (a_yel)          first_fault = FC_YEL_A;
    else if (b_yel)          first_fault = FC_YEL_B;
    else if (a_stuck)        first_fault = FC_STUCK_A;
    else if (b_stuck)        first_fault = FC_STUCK_B;

    state_d = state_q;
    issue_d = issue_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: if (in_enable) state_d = ST_MONITOR;
      ST_MONITOR: begin
        if (!in_enable) begin
          state_d = ST_IDLE;
        end else if (first_fault != FC_NONE) begin
          state_d = ST_FAULT;
          issue_d = 1'b1;
          code_d  = first_fault;
        end
      end
      default: state_d = ST_FAULT;
    endcase
    monitor_ok_d = (state_d == ST_MONITOR);
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      a_q          <= '0;
      a_p          <= '0;
      b_q          <= '0;
      b_p          <= '0;
      state_q      <= ST_IDLE;
      issue_q      <= 1'b0;
      code_q       <= FC_NONE;
      monitor_ok_q <= 1'b0;
      conf_cnt_q   <= '0;
    end else begin
      a_q          <= in_a_lights;
      a_p          <= a_q;
      b_q          <= in_b_lights;
      b_p          <= b_q;
      state_q      <= state_d;
      issue_q      <= issue_d;
      code_q       <= code_d;
      monitor_ok_q <= monitor_ok_d;
      conf_cnt_q   <= conf_cnt_d;
    end
  end

  assign out_issue      = issue_q;
  assign out_fault_code = code_q;
  assign out_monitor_ok = monitor_ok_q;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed scenarios plus random lamp sequences, all checked against a history-window model of the signalling rules.
module tb_light_conflict_monitor;

  localparam int T    = 4;
  localparam int MINY = 10;
  localparam int STK  = 100;

  localparam logic [4:0] L_RED = 5'b00001;
  localparam logic [4:0] L_YEL = 5'b00010;
  localparam logic [4:0] L_GRN = 5'b00100;
  localparam logic [4:0] L_LFT = 5'b01000;
  localparam logic [4:0] L_PED = 5'b10100;
  localparam logic [4:0] L_RY  = 5'b00011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [4:0] a   = 5'b0;
  logic [4:0] b   = 5'b0;
  logic       out_issue, out_monitor_ok;
  logic [2:0] out_fault_code;

  int total = 0;
  int bad   = 0;

  light_conflict_monitor #(
    .CONFLICT_FILTER_TICKS(32'd4),
    .MIN_YELLOW_TICKS     (32'd10),
    .STUCK_TICKS          (32'd100)
  ) dut (
    .in_clock(clk), .in_reset(rst), .in_enable(en),
    .in_a_lights(a), .in_b_lights(b),
    .out_issue(out_issue), .out_fault_code(out_fault_code), .out_monitor_ok(out_monitor_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: keep the lamp views seen during each monitored stretch and judge windows of it.
  typedef struct packed {
    logic [4:0] aq;
    logic [4:0] ap;
    logic [4:0] bq;
    logic [4:0] bp;
  } view_t;

  view_t      hist[$];
  logic [4:0] mq_a, mp_a, mq_b, mp_b;
  int         mstate;  // 0 idle, 1 monitoring, 2 faulted
  int         m_code;
  bit         m_issue;

  function automatic bit is_go(input logic [4:0] x);
    return x[1] || x[2] || x[3];
  endfunction

  function automatic bit is_illegal(input logic [4:0] x);
    int n = 0;
    for (int k = 0; k < 4; k++) if (x[k]) n++;
    return (n != 1) || (x[4] && !x[2]);
  endfunction

  function automatic logic [4:0] pick_q(input view_t v, input bit sel_b);
    return sel_b ? v.bq : v.aq;
  endfunction

  function automatic logic [4:0] pick_p(input view_t v, input bit sel_b);
    return sel_b ? v.bp : v.ap;
  endfunction

  function automatic bit window_all(input int kind, input int n);
    if (hist.size() < n) return 1'b0;
    for (int i = hist.size() - n; i < hist.size(); i++) begin
      view_t v;
      bit c;
      v = hist[i];
      case (kind)
        0:       c = is_go(v.aq) && is_go(v.bq);
        1:       c = is_illegal(v.aq);
        2:       c = is_illegal(v.bq);
        3:       c = (v.aq == v.ap);
        default: c = (v.bq == v.bp);
      endcase
      if (!c) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit yellow_bad(input bit sel_b);
    int n = hist.size();
    int run = 0;
    int i = n - 2;
    logic [4:0] cur, prv, h, fp;
    cur = pick_q(hist[n-1], sel_b);
    prv = pick_p(hist[n-1], sel_b);
    if (prv[2] && cur[0] && !cur[2]) return 1'b1;
    if (!(prv[1] && cur[0] && !cur[1])) return 1'b0;
    while (i >= 0) begin
      h = pick_q(hist[i], sel_b);
      if (!h[1]) break;
      run++;
      i--;
    end
    if (run == 0) return 1'b0;
    fp = pick_p(hist[i+1], sel_b);
    return !fp[1] && (run < MINY);
  endfunction

  task automatic model_reset();
    hist.delete();
    mq_a = '0; mp_a = '0; mq_b = '0; mp_b = '0;
    mstate = 0; m_code = 0; m_issue = 1'b0;
  endtask

  task automatic model_step();
    int code;
    if (rst) begin
      model_reset();
      return;
    end
    case (mstate)
      0: begin
        hist.delete();
        if (en) mstate = 1;
      end
      1: begin
        if (!en) begin
          mstate = 0;
          hist.delete();
        end else begin
          hist.push_back('{aq: mq_a, ap: mp_a, bq: mq_b, bp: mp_b});
          code = 0;
          if      (window_all(0, T))   code = 1;
          else if (window_all(1, T))   code = 2;
          else if (window_all(2, T))   code = 3;
          else if (yellow_bad(1'b0))   code = 4;
          else if (yellow_bad(1'b1))   code = 5;
          else if (window_all(3, STK)) code = 6;
          else if (window_all(4, STK)) code = 7;
          if (code != 0) begin
            mstate  = 2;
            m_issue = 1'b1;
            m_code  = code;
          end
        end
      end
      default: ;
    endcase
    mp_a = mq_a; mq_a = a;
    mp_b = mq_b; mq_b = b;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("issue", out_issue, m_issue);
    chk("code", out_fault_code, m_code);
    chk("monitor_ok", out_monitor_ok, (mstate == 1));
  endtask

  task automatic hold(input logic [4:0] xa, input logic [4:0] xb, input int n);
    a = xa;
    b = xb;
    repeat (n) cycle();
  endtask

  task automatic do_reset(input bit enable);
    rst = 1'b1;
    a   = L_RED;
    b   = L_RED;
    en  = enable;
    #1;
    model_reset();
    chk("rst_issue", out_issue, 0);
    chk("rst_code", out_fault_code, 0);
    chk("rst_ok", out_monitor_ok, 0);
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] pick_lamp();
    case ($urandom_range(0, 9))
      0, 1, 2: return L_RED;
      3:       return L_YEL;
      4, 5:    return L_GRN;
      6:       return L_LFT;
      7:       return L_PED;
      8:       return L_RY;
      default: return 5'b00000;
    endcase
  endfunction

  initial begin
    model_reset();

    // Legal full cycle with roles swapping.
    do_reset(1'b1);
    hold(L_GRN, L_RED, 20); hold(L_YEL, L_RED, 12); hold(L_RED, L_RED, 3);
    hold(L_RED, L_GRN, 20); hold(L_RED, L_YEL, 12); hold(L_RED, L_RED, 3);
    chk("s1_issue", out_issue, 0);
    chk("s1_code", out_fault_code, 0);

    // Conflict filter: 3-cycle overlap is tolerated, a longer one faults on the 5th edge.
    do_reset(1'b1);
    hold(L_GRN, L_RED, 3); hold(L_GRN, L_LFT, 3); hold(L_GRN, L_RED, 5);
    chk("s2_short_issue", out_issue, 0);
    hold(L_GRN, L_LFT, 4);
    chk("s2_edge4_issue", out_issue, 0);
    hold(L_GRN, L_LFT, 1);
    chk("s2_issue", out_issue, 1);
    chk("s2_code", out_fault_code, 1);

    // Short yellow, then direct green->red.
    do_reset(1'b1);
    hold(L_GRN, L_RED, 3); hold(L_YEL, L_RED, 6); hold(L_RED, L_RED, 1);
    chk("s3_edge1_issue", out_issue, 0);
    hold(L_RED, L_RED, 1);
    chk("s3_short_code", out_fault_code, 4);
    do_reset(1'b1);
    hold(L_GRN, L_RED, 3); hold(L_RED, L_RED, 2);
    chk("s3_g2r_code", out_fault_code, 4);

    // Conflict and illegal pattern in the same cycle: conflict wins.
    do_reset(1'b1);
    hold(L_RED, L_RED, 3); hold(L_RY, L_GRN, 4);
    chk("s4_pre_issue", out_issue, 0);
    hold(L_RED, L_RED, 1);
    chk("s4_code", out_fault_code, 1);

    // B frozen red while A cycles legally.
    do_reset(1'b1);
    repeat (2) begin
      hold(L_GRN, L_RED, 20); hold(L_YEL, L_RED, 12); hold(L_RED, L_RED, 20);
    end
    chk("s5_stuck_code", out_fault_code, 7);

    // Enable during a yellow already in progress: its end is not judged.
    do_reset(1'b0);
    hold(L_GRN, L_RED, 3); hold(L_YEL, L_RED, 2);
    en = 1'b1;
    hold(L_YEL, L_RED, 3); hold(L_RED, L_RED, 5);
    chk("s5_midyel_issue", out_issue, 0);
    chk("s5_midyel_ok", out_monitor_ok, 1);

    // Reset from FAULT clears outputs at once; monitoring returns one edge after release.
    do_reset(1'b1);
    hold(L_GRN, L_RED, 2); hold(L_GRN, L_GRN, 5);
    chk("s6_fault_issue", out_issue, 1);
    do_reset(1'b1);
    hold(L_RED, L_RED, 1);
    chk("s6_ok", out_monitor_ok, 1);

    // Random lamp sequences.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 19) == 0 || (m_issue && $urandom_range(0, 2) == 0))
        do_reset(1'($urandom_range(0, 1)));
      en = ($urandom_range(0, 9) != 0);
      hold(pick_lamp(), pick_lamp(), $urandom_range(1, 14));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
